// File: rtl/load_unit_pkg.sv
// Shared constants for the load unit: load-type encodings, FSM states and
// the alignment/legality rule used when a request is accepted.
package load_unit_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // A request is rejected for an unknown type or a misaligned half/word.
    function automatic logic load_illegal(input logic [2:0] lt, input logic [1:0] off);
        logic bad;
        case (lt)
            LT_LB, LT_LBU: bad = 1'b0;
            LT_LH, LT_LHU: bad = off[0];
            LT_LW:         bad = |off;
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword extraction from a little-endian read word,
// followed by sign or zero extension according to the load type.
module load_extend
    import load_unit_pkg::*;
(
    input  logic [2:0]  ltype,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        result   = '0;
        case (ltype)
            LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  result = {24'h000000, byte_sel};
            LT_LH:   result = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  result = {16'h0000, half_sel};
            LT_LW:   result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts one load at a time, reads the aligned word from memory
// with a bounded wait, and returns the extended result with a done pulse.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [2:0]  ltype,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        timeout,
    output logic [1:0]  dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q;
    logic [31:0]      addr_q;
    logic [2:0]       ltype_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      res_q;
    logic             adel_flag_q;
    logic             to_flag_q;

    logic             ready_q;
    logic             mem_re_q;
    logic [31:0]      mem_addr_q;
    logic             done_q;
    logic [31:0]      rdata_q;
    logic             adel_q;
    logic             timeout_q;

    logic [31:0]      ext_d;
    logic             req_bad_d;
    logic             wait_expired_d;

    load_extend u_extend (
        .ltype  (ltype_q),
        .offset (addr_q[1:0]),
        .word   (mem_rdata),
        .result (ext_d)
    );

    assign req_bad_d      = load_illegal(ltype, addr[1:0]);
    assign wait_expired_d = (cnt_q == CNT_LAST);

    // The result and flags are staged in DONE and published together with
    // the done pulse, so rdata only ever changes on a done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            ltype_q     <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            adel_flag_q <= 1'b0;
            to_flag_q   <= 1'b0;
            ready_q     <= 1'b1;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            adel_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            adel_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        addr_q      <= addr;
                        ltype_q     <= ltype;
                        cnt_q       <= '0;
                        to_flag_q   <= 1'b0;
                        ready_q     <= 1'b0;
                        if (req_bad_d) begin
                            // Rejected loads never touch memory and return zero.
                            adel_flag_q <= 1'b1;
                            res_q       <= '0;
                            state_q     <= ST_DONE;
                        end else begin
                            adel_flag_q <= 1'b0;
                            mem_re_q    <= 1'b1;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            state_q     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        res_q      <= ext_d;
                        mem_re_q   <= 1'b0;
                        mem_addr_q <= '0;
                        state_q    <= ST_DONE;
                    end else if (wait_expired_d) begin
                        res_q      <= '0;
                        to_flag_q  <= 1'b1;
                        mem_re_q   <= 1'b0;
                        mem_addr_q <= '0;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q    <= 1'b1;
                    rdata_q   <= res_q;
                    adel_q    <= adel_flag_q;
                    timeout_q <= to_flag_q;
                    ready_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    ready_q    <= 1'b1;
                    mem_re_q   <= 1'b0;
                    mem_addr_q <= '0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign adel      = adel_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed loads with hand-computed results, checked
// every cycle against an arithmetic model of the load rules.
module tb_load_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  ltype;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ready;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic        done;
    logic [31:0] rdata;
    logic        adel;
    logic        timeout;
    logic [1:0]  dbg_state;

    load_unit #(.MEM_TIMEOUT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ready      (ready),
        .addr       (addr),
        .ltype      (ltype),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .done       (done),
        .rdata      (rdata),
        .adel       (adel),
        .timeout    (timeout),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state owned by the driver: what the handshake outputs must be now.
    logic        exp_ready;
    logic        exp_mem_re;
    logic [31:0] exp_mem_addr;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic        adel;
        logic        to;
        logic        lit_v;
        logic [31:0] lit;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic model_illegal(input logic [2:0] lt, input int unsigned a);
        int unsigned sz;
        if (lt == 3'd0 || lt == 3'd4)      sz = 1;
        else if (lt == 3'd1 || lt == 3'd5) sz = 2;
        else if (lt == 3'd3)               sz = 4;
        else                               sz = 0;
        return (sz == 0) || (a % sz != 0);
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] lt, input int unsigned a,
                                              input int unsigned w);
        int unsigned off;
        int unsigned v;
        off = a % 4;
        if (lt == 3'd3) return w;
        if (lt == 3'd0 || lt == 3'd4) begin
            v = (w >> (8 * off)) % 256;
            if (lt == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (w >> (8 * off)) % 65536;
            if (lt == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Compare process: every cycle out of reset, all outputs against the model.
    initial begin
        logic [31:0] m_rdata;
        logic        exp_done;
        exp_t        e;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_rdata = '0;
                exp_q.delete();
            end else begin
                check1("ready", ready, exp_ready);
                check1("mem_re", mem_re, exp_mem_re);
                check32("mem_addr", mem_addr, exp_mem_re ? exp_mem_addr : 32'h0);
                exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
                check1("done", done, exp_done);
                check1("adel_timeout_excl", adel & timeout, 1'b0);
                if (exp_done) begin
                    e = exp_q.pop_front();
                    check32("rdata", rdata, e.rdata);
                    check1("adel", adel, e.adel);
                    check1("timeout", timeout, e.to);
                    if (e.lit_v) check32("rdata_literal", rdata, e.lit);
                    m_rdata = e.rdata;
                end else begin
                    check1("adel_idle", adel, 1'b0);
                    check1("timeout_idle", timeout, 1'b0);
                    check32("rdata_hold", rdata, m_rdata);
                end
            end
        end
    end

    // lat = WAIT cycle on which mem_rvalid is given; 0 or >T means never.
    task automatic do_load(input logic [31:0] a, input logic [2:0] lt, input int lat,
                           input logic [31:0] w, input logic lit_v, input logic [31:0] lit);
        int unsigned s;
        int          n;
        logic        ill;
        logic        timed;
        exp_t        e;
        req = 1'b1; addr = a; ltype = lt;
        exp_ready = 1'b1; exp_mem_re = 1'b0;
        s   = cyc;
        ill = model_illegal(lt, a);
        @(posedge clk); #1;
        req = 1'b0; addr = $urandom; ltype = 3'($urandom_range(0, 7));
        if (ill) begin
            e = '{cyc: s + 2, rdata: 32'h0, adel: 1'b1, to: 1'b0, lit_v: lit_v, lit: lit};
            exp_q.push_back(e);
            exp_ready = 1'b0; exp_mem_re = 1'b0;
        end else begin
            timed = (lat < 1) || (lat > T);
            n = 0;
            for (int k = 1; k <= T; k++) begin
                exp_ready = 1'b0; exp_mem_re = 1'b1; exp_mem_addr = a & 32'hFFFF_FFFC;
                n = k;
                mem_rvalid = (k == lat);
                mem_rdata  = (k == lat) ? w : $urandom;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                if (k == lat) break;
            end
            e = '{cyc: s + n + 2, rdata: timed ? 32'h0 : model_ext(lt, a, w),
                  adel: 1'b0, to: timed, lit_v: lit_v, lit: lit};
            exp_q.push_back(e);
            exp_ready = 1'b0; exp_mem_re = 1'b0;
        end
        // DONE state: a fresh request and stray read data must both be ignored.
        req = 1'b1; addr = 32'h0000_0203; ltype = 3'b011;
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1;
        req = 1'b0; mem_rvalid = 1'b0;
        exp_ready = 1'b1; exp_mem_re = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [2:0]  lt;
        int          lat;
        logic [31:0] w;
        logic [31:0] lit;
    } vec_t;

    initial begin
        vec_t vecs[18];
        vecs = '{
            '{32'h0000_0100, 3'b011, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
            '{32'h0000_0103, 3'b000, 1, 32'h8011_2233, 32'hFFFF_FF80},
            '{32'h0000_0103, 3'b100, 3, 32'h8011_2233, 32'h0000_0080},
            '{32'h0000_0102, 3'b001, 1, 32'h8011_2233, 32'hFFFF_8011},
            '{32'h0000_0102, 3'b101, 2, 32'h8011_2233, 32'h0000_8011},
            '{32'h0000_0102, 3'b011, 1, 32'h1111_1111, 32'h0000_0000},
            '{32'h0000_0101, 3'b001, 1, 32'h1111_1111, 32'h0000_0000},
            '{32'h0000_0200, 3'b010, 1, 32'h1111_1111, 32'h0000_0000},
            '{32'h0000_0201, 3'b110, 1, 32'h1111_1111, 32'h0000_0000},
            '{32'h0000_0204, 3'b111, 1, 32'h1111_1111, 32'h0000_0000},
            '{32'h0000_0101, 3'b000, 1, 32'h0000_7F00, 32'h0000_007F},
            '{32'h0000_0300, 3'b011, 0, 32'h5555_5555, 32'h0000_0000},
            '{32'h0000_0300, 3'b011, 4, 32'h1234_5678, 32'h1234_5678},
            '{32'h0000_0100, 3'b101, 2, 32'hABCD_FFFF, 32'h0000_FFFF},
            '{32'h0000_0100, 3'b001, 1, 32'hABCD_FFFF, 32'hFFFF_FFFF},
            '{32'h0000_0104, 3'b100, 3, 32'h1234_5680, 32'h0000_0080},
            '{32'h0000_0106, 3'b000, 2, 32'h0080_0000, 32'hFFFF_FF80},
            '{32'h0000_0102, 3'b001, 4, 32'h7FFF_0000, 32'h0000_7FFF}
        };

        reset = 1'b1; req = 1'b0; addr = '0; ltype = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        exp_ready = 1'b1; exp_mem_re = 1'b0; exp_mem_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 18; i++)
            do_load(vecs[i].a, vecs[i].lt, vecs[i].lat, vecs[i].w, 1'b1, vecs[i].lit);

        // Idle gap, then legal loads with varied data, offsets and latencies.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  lt;
            logic [31:0] a;
            case ($urandom_range(0, 4))
                0:       lt = 3'b000;
                1:       lt = 3'b001;
                2:       lt = 3'b011;
                3:       lt = 3'b100;
                default: lt = 3'b101;
            endcase
            a = $urandom;
            if (lt == 3'b011)                      a[1:0] = 2'b00;
            else if (lt == 3'b001 || lt == 3'b101) a[0]   = 1'b0;
            do_load(a, lt, $urandom_range(1, T), $urandom | 32'h1, 1'b0, 32'h0);
        end
        do_load(32'h0000_0010, 3'b011, 1, 32'hA5A5_0001, 1'b1, 32'hA5A5_0001);

        // Reset on the 2nd WAIT cycle, with read data in the same cycle.
        req = 1'b1; addr = 32'h0000_0400; ltype = 3'b011;
        exp_ready = 1'b1; exp_mem_re = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        exp_ready = 1'b0; exp_mem_re = 1'b1; exp_mem_addr = 32'h0000_0400;
        @(posedge clk); #1;
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        reset = 1'b0; mem_rvalid = 1'b0;
        exp_ready = 1'b1; exp_mem_re = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        do_load(32'h0000_0500, 3'b100, 2, 32'h0000_00F0, 1'b1, 32'h0000_00F0);
        repeat (4) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
